// File: rtl/updown_counter_div.sv
// updown_counter_div: up/down modulo counter with a programmable prescaler.
// The prescaler issues a step every div+1 enabled cycles; each step moves the
// count toward a bound inside 0..modulo, wrapping or saturating there, and a
// one-cycle terminal-count pulse marks every step taken at a bound.
module updown_counter_div #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             ud,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulo,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             tc_q, tc_d;

    logic             step;
    logic [WIDTH-1:0] cnt_step;
    logic             bound;

    // Step enable straight from the prescaler compare; no register stage.
    always_comb begin
        step = en && (pre_q == div);
        tick = step;
    end

    // Counter value a step would produce, and whether the pre-step count sits
    // on (or, after modulo was lowered, beyond) a bound.
    always_comb begin
        cnt_step = cnt_q;
        bound    = 1'b0;
        if (cnt_q > modulo) begin
            cnt_step = modulo;
            bound    = 1'b1;
        end else if (ud) begin
            if (cnt_q == modulo) begin
                bound    = 1'b1;
                cnt_step = sat ? cnt_q : '0;
            end else begin
                cnt_step = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == '0) begin
                bound    = 1'b1;
                cnt_step = sat ? '0 : modulo;
            end else begin
                cnt_step = cnt_q - 1'b1;
            end
        end
    end

    // Next-state selection: clear > load > step > prescale > hold.
    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        if (clear) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (load) begin
            cnt_d = (load_val > modulo) ? modulo : load_val;
            pre_d = '0;
        end else if (step) begin
            cnt_d = cnt_step;
            pre_d = '0;
            tc_d  = bound;
        end else if (en) begin
            // Wraps modulo 2^DIV_W if div was lowered below the current phase.
            pre_d = pre_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
        end
    end

    assign q  = cnt_q;
    assign tc = tc_q;

endmodule
